// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the BCD scan display: segment patterns, FSM states, nibble width.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g,dp}, with dp always off.
package bcd_scan_display_pkg;

    localparam int BCD_NIBBLE = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_DIGIT [0:9] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
        8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001
    };

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

endpackage

// File: rtl/bcd_scan_display_seg7_encode.sv
// Nibble to active-low 7-segment pattern; any value above 9 renders blank.
module seg7_encode
    import bcd_scan_display_pkg::*;
(
    input  logic [BCD_NIBBLE-1:0] nibble_i,
    output logic [7:0]            seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nibble_i)
            4'd0: seg_o = SEG_DIGIT[0];
            4'd1: seg_o = SEG_DIGIT[1];
            4'd2: seg_o = SEG_DIGIT[2];
            4'd3: seg_o = SEG_DIGIT[3];
            4'd4: seg_o = SEG_DIGIT[4];
            4'd5: seg_o = SEG_DIGIT[5];
            4'd6: seg_o = SEG_DIGIT[6];
            4'd7: seg_o = SEG_DIGIT[7];
            4'd8: seg_o = SEG_DIGIT[8];
            4'd9: seg_o = SEG_DIGIT[9];
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Iterative double-dabble binary-to-BCD converter feeding a multiplexed
// common-anode 7-segment bank (active-low segments and digit enables).
module bcd_scan_display
    import bcd_scan_display_pkg::*;
#(
    parameter int IN_W     = 4,
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  logic [IN_W-1:0]              bin_in,
    output logic                         busy,
    output logic [BCD_NIBBLE*DIGITS-1:0] bcd_out,
    output logic                         bcd_valid,
    output logic [7:0]                   seg_out,
    output logic [DIGITS-1:0]            dig_en
);

    localparam int BCD_W = BCD_NIBBLE * DIGITS;
    localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PRE_W = $clog2(PRESCALE);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_W - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]  scratch_q, scratch_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              valid_q, valid_d;
    logic [BCD_W-1:0]  adj;
    logic [BCD_W+IN_W-1:0] shifted;

    // One double-dabble step per edge: add-3 correction, then a joint left shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[i*BCD_NIBBLE +: BCD_NIBBLE] >= 4'd5)
                adj[i*BCD_NIBBLE +: BCD_NIBBLE] = scratch_q[i*BCD_NIBBLE +: BCD_NIBBLE] + 4'd3;
        end
        shifted = {adj, shreg_q} << 1;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    shreg_d   = bin_in;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONV;
                end
            end
            CONV: begin
                scratch_d = shifted[BCD_W+IN_W-1 -: BCD_W];
                shreg_d   = shifted[IN_W-1:0];
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    bcd_d   = shifted[BCD_W+IN_W-1 -: BCD_W];
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            shreg_q   <= '0;
            scratch_q <= '0;
            bcd_q     <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            bcd_q     <= bcd_d;
            valid_q   <= valid_d;
        end
    end

    assign busy      = (state_q == CONV);
    assign bcd_out   = bcd_q;
    assign bcd_valid = valid_q;

    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     dig_q, dig_d;
    logic                  tick;
    logic                  blank;
    logic [BCD_NIBBLE-1:0] nib_sel;
    logic [7:0]            enc_seg;

    assign tick = (pre_q == PRE_LAST);

    // Digit i>0 is blanked only if it and every more significant nibble are zero.
    always_comb begin
        nib_sel = '0;
        blank   = (idx_q != '0);
        dig_d   = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                nib_sel  = bcd_q[i*BCD_NIBBLE +: BCD_NIBBLE];
                dig_d[i] = 1'b0;
            end
            if ((IDX_W'(i) >= idx_q) && (bcd_q[i*BCD_NIBBLE +: BCD_NIBBLE] != '0))
                blank = 1'b0;
        end
    end

    seg7_encode u_seg7_encode (
        .nibble_i (nib_sel),
        .seg_o    (enc_seg)
    );

    always_comb begin
        pre_d = tick ? '0 : pre_q + 1'b1;
        idx_d = idx_q;
        seg_d = seg_q;
        if (tick) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            seg_d = blank ? SEG_BLANK : enc_seg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            idx_q <= '0;
            seg_q <= SEG_BLANK;
            dig_q <= '1;
        end else begin
            pre_q <= pre_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            if (tick)
                dig_q <= dig_d;
        end
    end

    assign seg_out = seg_q;
    assign dig_en  = dig_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display with a short scan prescale.
module tb_bcd_scan_display;

    localparam int IN_W     = 4;
    localparam int DIGITS   = 2;
    localparam int PRESCALE = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [3:0]  bin_in;
    logic        busy;
    logic [7:0]  bcd_out;
    logic        bcd_valid;
    logic [7:0]  seg_out;
    logic [1:0]  dig_en;

    int checks = 0;
    int errors = 0;
    int valid_seen = 0;
    int v0;
    int n;

    bcd_scan_display #(
        .IN_W     (IN_W),
        .DIGITS   (DIGITS),
        .PRESCALE (PRESCALE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .bin_in    (bin_in),
        .busy      (busy),
        .bcd_out   (bcd_out),
        .bcd_valid (bcd_valid),
        .seg_out   (seg_out),
        .dig_en    (dig_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bcd_valid === 1'b1) valid_seen++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with load low; leaves the bench at the negedge after the valid cycle.
    task automatic convert(input logic [3:0] val, input logic [7:0] exp_bcd);
        load = 1'b1;
        bin_in = val;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        check_eq("busy_c0", {31'd0, busy}, 32'd1);
        repeat (3) begin
            @(negedge clk);
            check_eq("busy_cn", {31'd0, busy}, 32'd1);
            check_eq("valid_early", {31'd0, bcd_valid}, 32'd0);
        end
        @(negedge clk);
        check_eq("busy_done", {31'd0, busy}, 32'd0);
        check_eq("valid_pulse", {31'd0, bcd_valid}, 32'd1);
        check_eq("bcd_out", {24'd0, bcd_out}, {24'd0, exp_bcd});
        @(negedge clk);
        check_eq("valid_drop", {31'd0, bcd_valid}, 32'd0);
    endtask

    task automatic wait_slot(input string tag, input logic [1:0] exp_dig, input logic [7:0] exp_seg);
        int k;
        k = 0;
        while (dig_en !== exp_dig && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_dig"}, {30'd0, dig_en}, {30'd0, exp_dig});
        check_eq({tag, "_seg"}, {24'd0, seg_out}, {24'd0, exp_seg});
    endtask

    initial begin
        rst_n  = 1'b0;
        load   = 1'b0;
        bin_in = 4'd0;
        repeat (2) @(negedge clk);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_bcd", {24'd0, bcd_out}, 32'd0);
        check_eq("rst_valid", {31'd0, bcd_valid}, 32'd0);
        check_eq("rst_seg", {24'd0, seg_out}, 32'hFF);
        check_eq("rst_dig", {30'd0, dig_en}, 32'd3);

        // Release: three edges before the first tick, then slots every PRESCALE edges.
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("pre_tick_seg", {24'd0, seg_out}, 32'hFF);
            check_eq("pre_tick_dig", {30'd0, dig_en}, 32'd3);
        end
        @(negedge clk);
        check_eq("tick1_dig", {30'd0, dig_en}, 32'd2);
        check_eq("tick1_seg", {24'd0, seg_out}, 32'h03);
        repeat (4) @(negedge clk);
        check_eq("tick2_dig", {30'd0, dig_en}, 32'd1);
        check_eq("tick2_seg", {24'd0, seg_out}, 32'hFF);

        convert(4'd14, 8'h14);
        repeat (16) @(negedge clk);
        wait_slot("d14_0", 2'b10, 8'b10011001);
        wait_slot("d14_1", 2'b01, 8'b10011111);

        convert(4'd7, 8'h07);
        repeat (16) @(negedge clk);
        wait_slot("d7_0", 2'b10, 8'b00011111);
        wait_slot("d7_1", 2'b01, 8'hFF);

        // Load while busy is ignored.
        v0 = valid_seen;
        load = 1'b1;
        bin_in = 4'd9;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        load = 1'b1;
        bin_in = 4'd3;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        repeat (10) @(negedge clk);
        check_eq("busy_ign_cnt", valid_seen - v0, 32'd1);
        check_eq("busy_ign_bcd", {24'd0, bcd_out}, 32'h09);

        // Load in the valid cycle is accepted.
        v0 = valid_seen;
        load = 1'b1;
        bin_in = 4'd9;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        n = 0;
        while (bcd_valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check_eq("b2b_first_valid", {31'd0, bcd_valid}, 32'd1);
        check_eq("b2b_first_bcd", {24'd0, bcd_out}, 32'h09);
        load = 1'b1;
        bin_in = 4'd15;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        check_eq("b2b_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        check_eq("b2b_second_valid", {31'd0, bcd_valid}, 32'd1);
        check_eq("b2b_second_bcd", {24'd0, bcd_out}, 32'h15);
        @(negedge clk);
        check_eq("b2b_pulses", valid_seen - v0, 32'd2);

        // Asynchronous reset in the middle of a conversion.
        repeat (12) @(negedge clk);
        load = 1'b1;
        bin_in = 4'd14;
        @(posedge clk);
        #1 load = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_eq("amid_busy", {31'd0, busy}, 32'd0);
        check_eq("amid_bcd", {24'd0, bcd_out}, 32'd0);
        check_eq("amid_seg", {24'd0, seg_out}, 32'hFF);
        check_eq("amid_dig", {30'd0, dig_en}, 32'd3);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = valid_seen;
        repeat (20) @(negedge clk);
        check_eq("amid_no_valid", valid_seen - v0, 32'd0);
        check_eq("amid_idle", {31'd0, busy}, 32'd0);
        check_eq("amid_bcd_hold", {24'd0, bcd_out}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
